// File: rtl/uart_pkg.sv
// uart_pkg: types and link timing shared by the UART transmitter and receiver.
// Both ends of the link take their bit period from here.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_RX_MID_TICK  = UART_CLKS_PER_BIT / 2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: small show-ahead synchronous FIFO feeding the UART transmitter.
// Writes while full and reads while empty are dropped.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered UART transmitter, 8N1/8N2 framing, LSB first.
// The line is registered and moves on the same edge as the state change.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DEPTH        = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [UART_DATA_BITS-1:0]  in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       tx,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int TW = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] STOP_END = TW'(STOP_BITS * CLKS_PER_BIT - 1);

    uart_tx_state_t            state;
    logic [TW-1:0]             tick;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic [UART_DATA_BITS-1:0] head;
    logic                      full;
    logic                      empty;
    logic                      pop;
    logic                      bit_done;
    logic                      stop_done;

    assign bit_done  = tick == BIT_END;
    assign stop_done = tick == STOP_END;
    assign pop       = !empty && (state == IDLE || (state == STOP && stop_done));
    assign in_ready  = !full;
    assign busy      = state != IDLE;

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (in_valid),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (head),
        .count   (fifo_count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            tick    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        state <= START;
                        tick  <= '0;
                        shreg <= head;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        tick    <= '0;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        tick    <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        shreg   <= shreg >> 1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            tx <= shreg[1];
                        end
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                STOP: begin
                    if (stop_done) begin
                        tick <= '0;
                        // Chain straight into the next start bit when data is queued.
                        if (pop) begin
                            state <= START;
                            shreg <= head;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed and random bytes against a frame-level model.
// A negedge monitor decodes the line and pops expected bytes from a scoreboard.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int STOPB = 1;
    localparam int FRAME = (9 + STOPB) * CPB;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic [7:0]    in_data   = 8'h00;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic          tx;
    logic          busy;
    logic [CW-1:0] fifo_count;
    logic [7:0]    in_data2  = 8'h00;
    logic          in_valid2 = 1'b0;
    logic          in_ready2;
    logic          tx2;
    logic          busy2;
    logic [CW-1:0] fifo_count2;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH),
        .STOP_BITS    (STOPB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH),
        .STOP_BITS    (2)
    ) dut2 (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data2),
        .in_valid   (in_valid2),
        .in_ready   (in_ready2),
        .tx         (tx2),
        .busy       (busy2),
        .fifo_count (fifo_count2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    int         starts[$];
    int         push_cyc = 0;
    int         max_cnt = 0;

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Line monitor: one expected byte per frame, ideal waveform per clock.
    bit         in_frame = 1'b0;
    bit         bad      = 1'b0;
    bit         nxt      = 1'b0;
    bit         started  = 1'b0;
    int         fcnt     = 0;
    int         bad_at   = 0;
    int         pos      = 0;
    logic       lvl;
    logic [7:0] cur      = 8'h00;
    logic [7:0] got      = 8'h00;

    always @(negedge clk) begin
        if (!reset) begin
            in_frame = 1'b0;
            nxt      = 1'b0;
        end else begin
            started = 1'b0;
            if (!in_frame && tx === 1'b0) begin
                started  = 1'b1;
                in_frame = 1'b1;
                fcnt     = 0;
                bad      = 1'b0;
                got      = 8'h00;
                starts.push_back(cyc);
                if (exp_q.size() == 0) cur = 8'h00;
                else cur = exp_q.pop_front();
            end
            if (nxt || started) check("start_timing", started, nxt);
            check("busy", busy, in_frame);
            check("fifo_count", fifo_count, exp_q.size());
            check("in_ready", in_ready, exp_q.size() < DEPTH);
            if (int'(fifo_count) > max_cnt) max_cnt = fifo_count;
            if (in_frame) begin
                pos = fcnt / CPB;
                if (pos == 0) lvl = 1'b0;
                else if (pos <= 8) lvl = cur[pos-1];
                else lvl = 1'b1;
                if (tx !== lvl && !bad) begin
                    bad    = 1'b1;
                    bad_at = fcnt;
                end
                if (pos >= 1 && pos <= 8 && fcnt % CPB == CPB / 2) got[pos-1] = tx;
                fcnt++;
                if (fcnt == FRAME) begin
                    in_frame = 1'b0;
                    check("frame_data", got, cur);
                    check("frame_first_bad_clk", bad ? bad_at : -1, -1);
                end
            end
            nxt = !in_frame && exp_q.size() > 0;
        end
    end

    task automatic push(input logic [7:0] b, output int waited);
        waited = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 2000) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            check("push_timeout", waited, 0);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            exp_q.push_back(b);
            push_cyc = cyc;
        end
    endtask

    task automatic release_in();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int end_cyc);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((busy || exp_q.size() != 0) && k < 5000);
        check("idle_timeout", busy || exp_q.size() != 0, 0);
        end_cyc = cyc;
    endtask

    task automatic count_tx2(input logic want, output int n);
        n = 0;
        while (tx2 !== want && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int w;
        int e;
        int n0;
        int lo1;
        int hi;
        int lo2;
        int tail;

        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_in_ready", in_ready, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        push(8'hA5, w);
        release_in();
        wait_idle(e);
        check("latency_a5", starts[$] - push_cyc, 1);
        check("busy_len_a5", e - starts[$], FRAME);

        n0      = starts.size();
        max_cnt = 0;
        push(8'h01, w);
        push(8'h02, w);
        push(8'h03, w);
        release_in();
        wait_idle(e);
        check("peak_count", max_cnt, 2);
        check("b2b_gap_1", starts[n0+1] - starts[n0], FRAME);
        check("b2b_gap_2", starts[n0+2] - starts[n0+1], FRAME);
        check("busy_len_3", e - starts[n0], 3 * FRAME);

        max_cnt = 0;
        for (int i = 0; i < 6; i++) push(8'($urandom), w);
        check("sixth_waited", w > 0, 1);
        check("full_seen", max_cnt, DEPTH);
        release_in();
        wait_idle(e);

        n0 = starts.size();
        push(8'h00, w);
        push(8'h00, w);
        release_in();
        w = 0;
        while (starts.size() == n0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("rst_frame_started", starts.size() - n0, 1);
        while (cyc - starts[$] < 50 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("pre_rst_tx_low", tx, 0);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_fifo_count", fifo_count, 0);
        check("mid_rst_busy", busy, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        n0 = starts.size();
        repeat (2 * FRAME) @(negedge clk);
        check("no_restart", starts.size() - n0, 0);
        check("post_rst_tx", tx, 1);

        for (int it = 0; it < 25; it++) begin
            repeat ($urandom_range(0, 2 * FRAME)) @(negedge clk);
            for (int k = 0; k < int'($urandom_range(1, 6)); k++) push(8'($urandom), w);
            release_in();
        end
        wait_idle(e);

        @(negedge clk);
        in_data2  = 8'h00;
        in_valid2 = 1'b1;
        repeat (2) @(negedge clk);
        in_valid2 = 1'b0;
        check("stop2_fifo_count", fifo_count2, 1);
        count_tx2(1'b0, n0);
        check("stop2_start_wait", n0, 0);
        count_tx2(1'b1, lo1);
        count_tx2(1'b0, hi);
        count_tx2(1'b1, lo2);
        tail = 0;
        while (busy2 && tail < 1000) begin
            @(negedge clk);
            tail++;
        end
        check("stop2_low_1", lo1, 9 * CPB);
        check("stop2_gap", hi, 2 * CPB);
        check("stop2_frame_len", lo1 + hi, 11 * CPB);
        check("stop2_low_2", lo2, 9 * CPB);
        check("stop2_tail", tail, 2 * CPB);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
